// File: rtl/sd_write_photo_pkg.sv
// rtl/sd_write_photo_pkg.sv - BMP layout constants and FSM encoding for sd_write_photo
// Purpose: shared constants for the BMP header generator and the capture FSM.
// Contents: header/info sizes, bpp, resolution, sector geometry, default start sector, state enum.
package sd_write_photo_pkg;

  localparam int BMP_HEAD_BYTES = 54;
  localparam int BMP_INFO_BYTES = 40;
  localparam int BMP_HEAD_WORDS = 27;
  localparam int BMP_BPP        = 24;
  localparam int BMP_RES        = 2835;
  localparam int WORDS_PER_SEC  = 256;
  localparam int SEC_SHIFT      = $clog2(WORDS_PER_SEC);

  localparam logic [31:0] SEC_ADDR0_DEF = 32'd40992;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_SECTOR,
    ST_ADVANCE
  } state_t;

endpackage

// File: rtl/bmp_header_gen.sv
// rtl/bmp_header_gen.sv - combinational BMP header word lookup
// Purpose: maps a header word index (0..26) to the 16-bit word {first byte, second byte}.
// Ports: idx (word index), n (pixel count), width, height (latched frame size); word (header word).
module bmp_header_gen
  import sd_write_photo_pkg::*;
(
  input  logic [4:0]  idx,
  input  logic [31:0] n,
  input  logic [15:0] width,
  input  logic [15:0] height,
  output logic [15:0] word
);

  logic [31:0] img_size;
  logic [31:0] file_size;

  assign img_size  = n * 32'd3;
  assign file_size = img_size + 32'(BMP_HEAD_BYTES);

  // Fields are little-endian, so the low byte of each 16-bit half goes first.
  function automatic logic [15:0] le16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  always_comb begin
    word = 16'h0000;
    case (idx)
      5'd0:        word = 16'h424D;
      5'd1:        word = le16(file_size[15:0]);
      5'd2:        word = le16(file_size[31:16]);
      5'd5:        word = le16(16'(BMP_HEAD_BYTES));
      5'd7:        word = le16(16'(BMP_INFO_BYTES));
      5'd9:        word = le16(width);
      5'd11:       word = le16(height);
      5'd13:       word = le16(16'd1);
      5'd14:       word = le16(16'(BMP_BPP));
      5'd17:       word = le16(img_size[15:0]);
      5'd18:       word = le16(img_size[31:16]);
      5'd19, 5'd21: word = le16(16'(BMP_RES));
      default:     word = 16'h0000;
    endcase
  end

endmodule

// File: rtl/sd_write_photo.sv
// rtl/sd_write_photo.sv - stream a DDR frame to SD as a 24-bit BMP file
// Purpose: sequences sector writes, emits BMP header, packs pixel pairs into words, pads last sector.
// Ports: cap_start/img_width/img_height (capture request), pix_rd_req/pix_rd_data (DDR FIFO),
//        wr_start_en/wr_sec_addr/wr_busy/sd_wr_req/sd_wr_data (SD writer), cap_busy/cap_done (status).
module sd_write_photo
  import sd_write_photo_pkg::*;
#(
  parameter logic [31:0] SEC_ADDR0 = SEC_ADDR0_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cap_start,
  input  logic [15:0] img_width,
  input  logic [15:0] img_height,
  output logic        pix_rd_req,
  input  logic [23:0] pix_rd_data,
  output logic        wr_start_en,
  output logic [31:0] wr_sec_addr,
  input  logic        wr_busy,
  input  logic        sd_wr_req,
  output logic [15:0] sd_wr_data,
  output logic        cap_busy,
  output logic        cap_done
);

  state_t      state, state_next;
  logic [31:0] n_reg, total_words, sec_total, sec_cnt, word_cnt;
  logic [15:0] width_reg, height_reg;
  logic [8:0]  word_in_sec;     // saturates at 256; bit 8 marks an over-long sector
  logic [1:0]  phase;           // position within the 3-word pixel pair
  logic [1:0]  fph;             // pair fetch sequencer
  logic [23:0] p0, p1;
  logic        busy_d1, busy_d2;
  logic [15:0] head_word, cur_word;
  logic [31:0] n_in, tw_in, st_in;
  logic        busy_fall, last_sec, consume, fetch_go;

  assign n_in  = {16'd0, img_width} * {16'd0, img_height};
  assign tw_in = 32'(BMP_HEAD_WORDS) + ((n_in * 32'd3) >> 1);
  assign st_in = (tw_in + 32'(WORDS_PER_SEC - 1)) >> SEC_SHIFT;

  assign busy_fall = busy_d2 & ~busy_d1;
  assign last_sec  = (sec_cnt == sec_total - 32'd1);
  assign consume   = sd_wr_req && (state == ST_SECTOR) && !word_in_sec[8];

  // Fetch the next pair right after the word preceding its w0 is consumed;
  // the >=4 cycle request spacing leaves room for both reads to land.
  assign fetch_go = consume && (word_cnt + 32'd1 < total_words) &&
                    ((word_cnt == 32'(BMP_HEAD_WORDS - 1)) ||
                     ((word_cnt >= 32'(BMP_HEAD_WORDS)) && (phase == 2'd2)));

  bmp_header_gen u_hdr (
    .idx    (word_cnt[4:0]),
    .n      (n_reg),
    .width  (width_reg),
    .height (height_reg),
    .word   (head_word)
  );

  always_comb begin
    cur_word = 16'h0000;
    if (!word_in_sec[8]) begin
      if (word_cnt < 32'(BMP_HEAD_WORDS)) begin
        cur_word = head_word;
      end else if (word_cnt < total_words) begin
        case (phase)
          2'd0:    cur_word = {p0[7:0], p0[15:8]};
          2'd1:    cur_word = {p0[23:16], p1[7:0]};
          default: cur_word = {p1[15:8], p1[23:16]};
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (cap_start) state_next = ST_START;
      ST_START:   state_next = ST_SECTOR;
      ST_SECTOR:  if (busy_fall) state_next = ST_ADVANCE;
      ST_ADVANCE: state_next = last_sec ? ST_IDLE : ST_START;
      default:    state_next = ST_IDLE;
    endcase
  end

  assign wr_start_en = (state == ST_START);
  assign cap_busy    = (state != ST_IDLE);
  assign cap_done    = (state == ST_ADVANCE) && last_sec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_reg       <= '0;
      width_reg   <= '0;
      height_reg  <= '0;
      total_words <= '0;
      sec_total   <= '0;
      sec_cnt     <= '0;
      word_cnt    <= '0;
      word_in_sec <= '0;
      phase       <= '0;
      fph         <= '0;
      p0          <= '0;
      p1          <= '0;
      busy_d1     <= 1'b0;
      busy_d2     <= 1'b0;
      pix_rd_req  <= 1'b0;
      sd_wr_data  <= '0;
      wr_sec_addr <= '0;
    end else begin
      busy_d1 <= wr_busy;
      busy_d2 <= busy_d1;

      if (state == ST_IDLE && cap_start) begin
        n_reg       <= n_in;
        width_reg   <= img_width;
        height_reg  <= img_height;
        total_words <= tw_in;
        sec_total   <= st_in;
        sec_cnt     <= '0;
        word_cnt    <= '0;
        phase       <= '0;
        wr_sec_addr <= SEC_ADDR0;
      end

      if (state == ST_START) word_in_sec <= '0;

      if (state == ST_ADVANCE && !last_sec) begin
        sec_cnt     <= sec_cnt + 32'd1;
        wr_sec_addr <= SEC_ADDR0 + sec_cnt + 32'd1;
      end

      if (sd_wr_req && state == ST_SECTOR) begin
        sd_wr_data <= cur_word;
        if (!word_in_sec[8]) word_in_sec <= word_in_sec + 9'd1;
      end

      if (consume) begin
        word_cnt <= word_cnt + 32'd1;
        if (word_cnt >= 32'(BMP_HEAD_WORDS)) phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
      end

      // Read data lands one cycle after each request: p0 is captured two
      // cycles after the first request, p1 one cycle later.
      case (fph)
        2'd0: if (fetch_go) begin
          pix_rd_req <= 1'b1;
          fph        <= 2'd1;
        end
        2'd1: fph <= 2'd2;
        2'd2: begin
          p0         <= pix_rd_data;
          pix_rd_req <= 1'b0;
          fph        <= 2'd3;
        end
        default: begin
          p1  <= pix_rd_data;
          fph <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_write_photo.sv
// tb/tb_sd_write_photo.sv - directed self-checking bench for sd_write_photo
module tb_sd_write_photo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cap_start;
  logic [15:0] img_width, img_height;
  logic        pix_rd_req;
  logic [23:0] pix_rd_data = '0;
  logic        wr_start_en;
  logic [31:0] wr_sec_addr;
  logic        wr_busy;
  logic        sd_wr_req;
  logic [15:0] sd_wr_data;
  logic        cap_busy, cap_done;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int pix_cnt = 0;
  int pix_base = 0;
  int cap_s0 = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] addr_log [0:1];
  logic [15:0] got [0:511];
  logic [15:0] extra_word;
  logic [23:0] src [0:255];

  sd_write_photo dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cap_start   (cap_start),
    .img_width   (img_width),
    .img_height  (img_height),
    .pix_rd_req  (pix_rd_req),
    .pix_rd_data (pix_rd_data),
    .wr_start_en (wr_start_en),
    .wr_sec_addr (wr_sec_addr),
    .wr_busy     (wr_busy),
    .sd_wr_req   (sd_wr_req),
    .sd_wr_data  (sd_wr_data),
    .cap_busy    (cap_busy),
    .cap_done    (cap_done)
  );

  always #5 clk = ~clk;

  // DDR FIFO model: data for a request appears on the following cycle.
  always @(posedge clk) begin
    if (wr_start_en) begin
      start_cnt <= start_cnt + 1;
      last_addr <= wr_sec_addr;
    end
    if (cap_done) done_cnt <= done_cnt + 1;
    if (pix_rd_req) begin
      pix_rd_data <= src[8'(pix_cnt - pix_base)];
      pix_cnt     <= pix_cnt + 1;
    end
  end

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d]: got %h expected %h", tag, idx, obs, exp);
    end
  endtask

  // Reference BMP byte stream built byte by byte from the file layout.
  function automatic logic [7:0] bmp_byte(input int b, input int w, input int h);
    logic [31:0] n, fs, isz, wd, ht;
    int p;
    n = 32'(w * h); isz = n * 3; fs = isz + 54; wd = 32'(w); ht = 32'(h);
    if (b == 0) return 8'h42;
    if (b == 1) return 8'h4D;
    if (b >= 2 && b < 6) return fs[8*(b-2) +: 8];
    if (b == 10) return 8'd54;
    if (b == 14) return 8'd40;
    if (b >= 18 && b < 22) return wd[8*(b-18) +: 8];
    if (b >= 22 && b < 26) return ht[8*(b-22) +: 8];
    if (b == 26) return 8'd1;
    if (b == 28) return 8'd24;
    if (b >= 34 && b < 38) return isz[8*(b-34) +: 8];
    if (b == 38 || b == 42) return 8'h13;
    if (b == 39 || b == 43) return 8'h0B;
    if (b < 54) return 8'h00;
    p = (b - 54) / 3;
    if (p < w * h) return src[p][8*((b-54)%3) +: 8];
    return 8'h00;
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 cap_start = 1'b1;
    @(posedge clk); #1 cap_start = 1'b0;
  endtask

  task automatic sector(input int s, input int nreq, input bit poke, input int stop_after);
    int t;
    t = 0;
    while (start_cnt <= cap_s0 + s && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("start_seen", s, 32'(start_cnt > cap_s0 + s), 32'd1);
    if (s < 2) addr_log[s] = last_addr;
    wr_busy = 1'b1;
    for (int j = 0; j < nreq; j++) begin
      if (stop_after >= 0 && j == stop_after) return;
      @(posedge clk); #1 sd_wr_req = 1'b1;
      @(posedge clk); #1 sd_wr_req = 1'b0;
      if (j < 256) got[s*256 + j] = sd_wr_data;
      else extra_word = sd_wr_data;
      if (poke && j == 10) begin
        img_width = 16'd8; img_height = 16'd4;
        pulse_start();
      end
      repeat (3) @(posedge clk);
    end
    repeat (2) @(posedge clk);
    #1 wr_busy = 1'b0;
  endtask

  task automatic capture(input int w, input int h, input int nsec, input int extra_at,
                         input bit poke, input int abort_at);
    int d0, q0, t;
    d0 = done_cnt; q0 = pix_cnt; cap_s0 = start_cnt; pix_base = pix_cnt;
    img_width = 16'(w); img_height = 16'(h);
    for (int k = 0; k < 512; k++) got[k] = 16'hDEAD;
    extra_word = 16'hBEEF;
    pulse_start();
    for (int s = 0; s < nsec; s++) begin
      if (s == abort_at) begin
        sector(s, 256, 1'b0, 20);
        return;
      end
      sector(s, (s == extra_at) ? 257 : 256, poke && s == 0, -1);
    end
    t = 0;
    while (done_cnt == d0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("sectors", 0, 32'(start_cnt - cap_s0), 32'(nsec));
    chk("cap_done_cnt", 0, 32'(done_cnt - d0), 32'd1);
    chk("pix_reqs", 0, 32'(pix_cnt - q0), 32'(w * h));
    chk("busy_end", 0, 32'(cap_busy), 32'd0);
    for (int s = 0; s < nsec; s++) chk("sec_addr", s, addr_log[s], 32'd40992 + 32'(s));
    for (int k = 0; k < nsec * 256; k++)
      chk("word", k, 32'(got[k]), 32'({bmp_byte(2*k, w, h), bmp_byte(2*k+1, w, h)}));
    if (extra_at >= 0) chk("extra_word", extra_at, 32'(extra_word), 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 0, 32'(cap_busy), 32'd0);
    chk({tag, "_start"}, 0, 32'(wr_start_en), 32'd0);
    chk({tag, "_done"}, 0, 32'(cap_done), 32'd0);
    chk({tag, "_pixreq"}, 0, 32'(pix_rd_req), 32'd0);
    chk({tag, "_data"}, 0, 32'(sd_wr_data), 32'd0);
    chk({tag, "_addr"}, 0, wr_sec_addr, 32'd0);
  endtask

  initial begin
    int dsave;
    rst_n = 1'b0; cap_start = 1'b0; img_width = '0; img_height = '0;
    wr_busy = 1'b0; sd_wr_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 4x2 frame, ascending pixels: one sector, directed header words.
    for (int i = 0; i < 256; i++) src[i] = 24'(i);
    capture(4, 2, 1, -1, 1'b0, -1);
    chk("hdr_w0", 0, 32'(got[0]), 32'h424D);
    chk("hdr_w1", 1, 32'(got[1]), 32'h4E00);
    chk("hdr_w5", 5, 32'(got[5]), 32'h3600);
    chk("hdr_w9", 9, 32'(got[9]), 32'h0400);
    chk("hdr_w19", 19, 32'(got[19]), 32'h130B);
    chk("pix_w28", 28, 32'(got[28]), 32'h0001);
    chk("pad_w39", 39, 32'(got[39]), 32'h0000);

    // Pair packing with distinct byte values.
    src[0] = 24'h112233; src[1] = 24'h445566;
    capture(4, 2, 1, -1, 1'b0, -1);
    chk("pack_w27", 27, 32'(got[27]), 32'h3322);
    chk("pack_w28", 28, 32'(got[28]), 32'h1166);
    chk("pack_w29", 29, 32'(got[29]), 32'h5544);

    // 16x16 two-sector frame with a stray cap_start and size change mid-sector.
    for (int i = 0; i < 256; i++) src[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h5A};
    capture(16, 16, 2, -1, 1'b1, -1);
    chk("pad_w411", 411, 32'(got[411]), 32'h0000);
    chk("pad_w511", 511, 32'(got[511]), 32'h0000);

    // Reset during the second sector, then a clean re-capture.
    capture(16, 16, 2, -1, 1'b0, 1);
    #1 rst_n = 1'b0;
    #2;
    chk_idle("midreset");
    dsave = done_cnt;
    wr_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("no_done_on_reset", 0, 32'(done_cnt), 32'(dsave));
    capture(16, 16, 2, -1, 1'b0, -1);

    // 257 requests in the first sector.
    capture(16, 16, 2, 0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
